// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side adapter for the synchronous FIFO. It pops words from the FIFO's
// rd_en/rd_data/empty port, which has a one-cycle registered read latency.
// It presents them as a valid/ready stream at full throughput, with no data
// loss under backpressure. Output beats are grouped into fixed-length frames
// (m_last), and completed frames are counted in frame_cnt.
//
// A 2-entry skid buffer absorbs the read latency. A pop is issued only when
// the buffered words, plus the word still in flight, minus the beat leaving
// this cycle, would leave room for the returning data. The buffer therefore
// never overflows and never needs to drop a word.

module fifo_stream_reader #(
  parameter int WIDTH     = 8,   // data width, must match the FIFO
  parameter int FRAME_LEN = 8,   // beats per frame (>= 1)
  parameter int FCNT_W    = 16   // width of the completed-frame counter
) (
  input  logic              clk,
  input  logic              rst,          // synchronous, active-low
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  output logic [FCNT_W-1:0] frame_cnt
);

  // The beat counter needs at least one bit, even for single-beat frames.
  localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic [1:0]        cnt;        // words held in the skid buffer (0..2)
  logic              inflight;   // a pop was issued last cycle; data arrives now
  logic [WIDTH-1:0]  head_q;     // oldest buffered word, drives m_data
  logic [WIDTH-1:0]  tail_q;     // second buffered word
  logic [BEAT_W-1:0] beat_cnt;   // position of the head beat within its frame
  logic              pop;        // downstream accepts the head beat this cycle
  logic [2:0]        occupancy;  // words owned after this cycle's pop

  // The outputs are decoded directly from registered state.
  assign m_valid = (cnt != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

  // Pop-request logic. m_ready feeds fifo_rd_en combinationally, so a slot
  // freed this cycle can be refilled at once. This keeps one beat per cycle
  // in steady state.
  always_comb begin
    pop        = m_valid & m_ready;
    occupancy  = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = rst & ~fifo_empty & (occupancy < 3'd2);
  end

  // Skid buffer: data returning from the FIFO enters at the tail, and
  // accepted beats leave from the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the data entries are reset along with the control state, because
      // head_q is visible on m_data and must read zero out of reset. Storage
      // that is not observable would normally be left unreset.
      cnt      <= 2'd0;
      inflight <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      // NOTE: every register here uses non-blocking assignment. The case arms
      // below read the pre-edge values of cnt, head_q and tail_q, not values
      // updated earlier in this block.
      inflight <= fifo_rd_en;
      unique case ({inflight, pop})
        2'b10: begin
          // Write only: fill the first free slot.
          if (cnt == 2'd0) head_q <= fifo_rd_data;
          else             tail_q <= fifo_rd_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // Pop only: the tail word moves up to the head.
          head_q <= tail_q;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Pop and write together: the head advances, and the new word goes
          // to the tail. cnt is unchanged.
          if (cnt == 2'd1) begin
            head_q <= fifo_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame tracking: advance the beat position on each accepted beat, and count
  // a frame when its final beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt  <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader.
// Instance a: FRAME_LEN=8, FCNT_W=16. Instance b: FRAME_LEN=4, FCNT_W=3, which
// exercises frame wrap and frame-counter wrap. Each instance is fed by a small
// FIFO model with one-cycle registered read latency. A scoreboard checks data
// order and m_last on every accepted beat. Inputs change 1 ns after the
// posedge, and all sampling happens on the negedge.

module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- instance a ----------------
  logic        rst_a = 1'b0, m_ready_a = 1'b0, flush_a = 1'b0;
  logic        fifo_empty_a, fifo_rd_en_a, m_valid_a, m_last_a;
  logic [7:0]  fifo_rd_data_a = 8'h00, m_data_a;
  logic [15:0] frame_cnt_a;
  logic [7:0]  mem_a [0:255];
  logic [7:0]  wr_ptr_a = 8'd0, rd_ptr_a = 8'd0;
  logic [7:0]  exp_a [$];
  logic [7:0]  head_exp_a;
  int          beat_a = 0;

  assign fifo_empty_a = (rd_ptr_a == wr_ptr_a);

  fifo_stream_reader #(.WIDTH(8), .FRAME_LEN(8), .FCNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a),
    .fifo_rd_data(fifo_rd_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_last(m_last_a), .frame_cnt(frame_cnt_a));

  // FIFO model a: registered read, optional flush.
  always @(posedge clk) begin
    if (flush_a) begin
      rd_ptr_a <= wr_ptr_a;
    end else if (fifo_rd_en_a) begin
      fifo_rd_data_a <= mem_a[rd_ptr_a];
      rd_ptr_a       <= rd_ptr_a + 8'd1;
    end
  end

  // Monitor a: underflow guard, m_last model, data scoreboard.
  always @(negedge clk) begin
    if (fifo_rd_en_a === 1'b1) check("a_rd_en_while_empty", 32'(fifo_empty_a), 32'd0);
    if (m_valid_a === 1'b1) begin
      check("a_m_last", 32'(m_last_a), 32'(beat_a == 7));
      if (m_ready_a === 1'b1) begin
        check("a_beat_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          head_exp_a = exp_a.pop_front();
          check("a_scoreboard_data", 32'(m_data_a), 32'(head_exp_a));
        end
        beat_a = (beat_a == 7) ? 0 : beat_a + 1;
      end
    end
    if (rst_a === 1'b0) beat_a = 0;
  end

  task automatic push_a(input logic [7:0] d);
    mem_a[wr_ptr_a] = d;
    wr_ptr_a        = wr_ptr_a + 8'd1;
    exp_a.push_back(d);
  endtask

  // ---------------- instance b ----------------
  logic        rst_b = 1'b0, m_ready_b = 1'b0;
  logic        fifo_empty_b, fifo_rd_en_b, m_valid_b, m_last_b;
  logic [7:0]  fifo_rd_data_b = 8'h00, m_data_b;
  logic [2:0]  frame_cnt_b;
  logic [7:0]  mem_b [0:255];
  logic [7:0]  wr_ptr_b = 8'd0, rd_ptr_b = 8'd0;
  logic [7:0]  exp_b [$];
  logic [7:0]  head_exp_b;
  int          beat_b = 0;
  int          acc_b  = 0;

  assign fifo_empty_b = (rd_ptr_b == wr_ptr_b);

  fifo_stream_reader #(.WIDTH(8), .FRAME_LEN(4), .FCNT_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b),
    .fifo_rd_data(fifo_rd_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_last(m_last_b), .frame_cnt(frame_cnt_b));

  // FIFO model b: registered read.
  always @(posedge clk) begin
    if (fifo_rd_en_b) begin
      fifo_rd_data_b <= mem_b[rd_ptr_b];
      rd_ptr_b       <= rd_ptr_b + 8'd1;
    end
  end

  // Monitor b: underflow guard, m_last model, data scoreboard.
  always @(negedge clk) begin
    if (fifo_rd_en_b === 1'b1) check("b_rd_en_while_empty", 32'(fifo_empty_b), 32'd0);
    if (m_valid_b === 1'b1) begin
      check("b_m_last", 32'(m_last_b), 32'(beat_b == 3));
      if (m_ready_b === 1'b1) begin
        check("b_beat_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          head_exp_b = exp_b.pop_front();
          check("b_scoreboard_data", 32'(m_data_b), 32'(head_exp_b));
        end
        beat_b = (beat_b == 3) ? 0 : beat_b + 1;
        acc_b++;
      end
    end
  end

  task automatic push_b(input logic [7:0] d);
    mem_b[wr_ptr_b] = d;
    wr_ptr_b        = wr_ptr_b + 8'd1;
    exp_b.push_back(d);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;

    // T1: reset held with a non-empty FIFO.
    for (int i = 0; i < 4; i++) push_a(8'h11 * (i + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_rd_en", 32'(fifo_rd_en_a), 32'd0);
      check("t1_m_valid", 32'(m_valid_a), 32'd0);
      check("t1_m_data", 32'(m_data_a), 32'd0);
      check("t1_frame_cnt", 32'(frame_cnt_a), 32'd0);
    end
    next_cycle();
    for (int i = 4; i < 8; i++) push_a(8'h11 * (i + 1));

    // T2: full-rate stream of one frame.
    next_cycle();
    rst_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    check("t2_first_rd_en", 32'(fifo_rd_en_a), 32'd1);
    check("t2_valid_n", 32'(m_valid_a), 32'd0);
    @(negedge clk);
    check("t2_valid_n1", 32'(m_valid_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(m_valid_a), 32'd1);
      check("t2_data", 32'(m_data_a), 32'(8'h11 * (i + 1)));
      check("t2_last", 32'(m_last_a), 32'(i == 7));
    end
    @(negedge clk);
    check("t2_drained", 32'(m_valid_a), 32'd0);
    check("t2_frame_cnt", 32'(frame_cnt_a), 32'd1);

    // T3: backpressure with 8 words waiting.
    next_cycle();
    m_ready_a = 1'b0;
    for (int i = 0; i < 8; i++) push_a(8'h11 * (i + 1));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en_a) pulses++;
      if (i >= 2) begin
        check("t3_hold_valid", 32'(m_valid_a), 32'd1);
        check("t3_hold_data", 32'(m_data_a), 32'h11);
      end
    end
    check("t3_rd_en_pulses", 32'(pulses), 32'd2);
    next_cycle();
    m_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_valid", 32'(m_valid_a), 32'd1);
      check("t3_data", 32'(m_data_a), 32'(8'h11 * (i + 1)));
      check("t3_last", 32'(m_last_a), 32'(i == 7));
    end
    @(negedge clk);
    check("t3_drained", 32'(m_valid_a), 32'd0);
    check("t3_frame_cnt", 32'(frame_cnt_a), 32'd2);

    // T4: one word every 3 cycles, so the FIFO keeps running empty.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      push_a(8'hC0 + 8'(k));
      @(negedge clk);
      check("t4_rd_en", 32'(fifo_rd_en_a), 32'd1);
      check("t4_gap_valid0", 32'(m_valid_a), 32'd0);
      @(negedge clk);
      check("t4_rd_en_empty", 32'(fifo_rd_en_a), 32'd0);
      check("t4_gap_valid1", 32'(m_valid_a), 32'd0);
      @(negedge clk);
      check("t4_valid", 32'(m_valid_a), 32'd1);
      check("t4_data", 32'(m_data_a), 32'(8'hC0 + 8'(k)));
      check("t4_last", 32'(m_last_a), 32'(k == 7));
    end
    @(negedge clk);
    check("t4_frame_cnt", 32'(frame_cnt_a), 32'd3);

    // T6: reset mid-frame with two words buffered.
    next_cycle();
    for (int i = 0; i < 8; i++) push_a(8'h51 + 8'(i));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_pre_data", 32'(m_data_a), 32'(8'h51 + 8'(i)));
    end
    next_cycle();
    m_ready_a = 1'b0;
    @(negedge clk);
    check("t6_stall_data", 32'(m_data_a), 32'h54);
    check("t6_stall_rd_en", 32'(fifo_rd_en_a), 32'd0);
    next_cycle();
    rst_a = 1'b0; flush_a = 1'b1;
    exp_a.delete();
    @(negedge clk);
    check("t6_rst_rd_en", 32'(fifo_rd_en_a), 32'd0);
    check("t6_buffered_head", 32'(m_data_a), 32'h54);
    next_cycle();
    flush_a = 1'b0;
    for (int i = 0; i < 8; i++) push_a(8'hA0 + 8'(i));
    @(negedge clk);
    check("t6_valid_after_rst", 32'(m_valid_a), 32'd0);
    check("t6_data_after_rst", 32'(m_data_a), 32'd0);
    check("t6_frame_cnt_rst", 32'(frame_cnt_a), 32'd0);
    check("t6_rd_en_in_rst", 32'(fifo_rd_en_a), 32'd0);
    next_cycle();
    rst_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    check("t6_rd_en_release", 32'(fifo_rd_en_a), 32'd1);
    @(negedge clk);
    check("t6_valid_n1", 32'(m_valid_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_valid", 32'(m_valid_a), 32'd1);
      check("t6_data", 32'(m_data_a), 32'(8'hA0 + 8'(i)));
      check("t6_last", 32'(m_last_a), 32'(i == 7));
    end
    @(negedge clk);
    check("t6_frame_cnt", 32'(frame_cnt_a), 32'd1);

    // T5: FRAME_LEN=4, 16 words, random m_ready.
    next_cycle();
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) push_b(8'h30 + 8'(i));
    for (int i = 0; i < 400 && acc_b < 16; i++) begin
      next_cycle();
      m_ready_b = 1'($urandom_range(0, 1));
    end
    check("t5_beats_accepted", 32'(acc_b), 32'd16);
    m_ready_b = 1'b1;
    @(negedge clk);
    check("t5_frame_cnt", 32'(frame_cnt_b), 32'd4);
    check("t5_drained", 32'(m_valid_b), 32'd0);

    // Frame counter wrap: 4 more frames take the 3-bit count from 4 to 0.
    next_cycle();
    for (int i = 0; i < 16; i++) push_b(8'h40 + 8'(i));
    for (int i = 0; i < 200 && acc_b < 32; i++) next_cycle();
    check("wrap_beats_accepted", 32'(acc_b), 32'd32);
    @(negedge clk);
    check("wrap_frame_cnt", 32'(frame_cnt_b), 32'd0);
    check("wrap_scoreboard_empty", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
